uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single `uart_tx` transmitter between `NUM_REQ` byte-stream requesters, for example command read responses and asynchronous status reports. Arbitration is round-robin and packet-locked: a winner keeps the transmitter until its last byte completes. The block sits between the monitor logic and `uart_tx`, and drives `tx_write`/`tx_byte` on their behalf. A watchdog releases the transmitter if it stops responding.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2 to 8.
- `NUM_DATA_BITS`, default 8: UART data width.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles per byte spent in SEND plus WAIT_DONE.

Ports:
- `clk` input, 1: single clock; the same clock that drives `uart_tx` (the `baud_tx` domain).
- `reset` input, 1: synchronous, active-high.
- `req` input, NUM_REQ: requester i holds its bit high for its whole packet.
- `req_byte` input, NUM_REQ*NUM_DATA_BITS: byte of requester i at bits `[i*NUM_DATA_BITS +: NUM_DATA_BITS]`.
- `req_last` input, NUM_REQ: the presented byte is the last of the packet.
- `req_ack` output, NUM_REQ: one-cycle pulse when the presented byte is consumed; the requester advances to its next byte.
- `grant` output, NUM_REQ: one-hot, identifies the current owner.
- `grant_id` output, $clog2(NUM_REQ): index of the owner, valid while `busy` is high.
- `busy` output, 1: the transmitter is owned.
- `tx_write` output, 1: to `uart_tx.write`.
- `tx_byte` output, NUM_DATA_BITS: to `uart_tx.data`.
- `tx_busy` input, 1: from `uart_tx`.
- `tx_done` input, 1: from `uart_tx`.
- `abort_err` output, 1: sticky; a requester dropped `req` mid-packet.
- `timeout_err` output, 1: sticky; the watchdog expired.

## Operation
- States: IDLE, LOAD, SEND, WAIT_DONE.
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Round-robin pointer `rr_ptr` = NUM_REQ-1, so requester 0 wins first.
  - Watchdog counter 0.
- IDLE:
  - Search `req` starting at index (rr_ptr+1) mod NUM_REQ, wrapping around.
  - If a requester is found: latch its index g, assert `grant[g]` and `busy`, go to LOAD.
  - If none is found: stay in IDLE with outputs 0.
- LOAD:
  - If `req[g]` is 0 and no byte has been sent yet: release without error and go to IDLE. `rr_ptr` is not updated.
  - If `req[g]` is 0 after at least one byte has been sent: set `abort_err`, release, set `rr_ptr` = g, go to IDLE.
  - Otherwise:
    - `tx_byte` <= requester g's byte; latch `last` <= `req_last[g]`.
    - Pulse `req_ack[g]`; set `tx_write` <= 1; clear the watchdog; go to SEND.
- SEND:
  - Hold `tx_write` = 1 until `tx_busy` = 1 is sampled.
  - Then set `tx_write` <= 0 and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for `tx_done` = 1 and `tx_busy` = 0 with `tx_busy` = 1 on the previous cycle, i.e. the falling edge of busy.
  - If `last` = 1: release (`grant`, `busy` and `grant_id` to 0), set `rr_ptr` = g, go to IDLE.
  - If `last` = 0: go to LOAD.
- Watchdog:
  - Increments every cycle in SEND and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: set `timeout_err`, `tx_write` <= 0, release, set `rr_ptr` = g, go to IDLE.
- `tx_byte` holds its value until the next LOAD.
- `req` changes on non-owners never disturb the current packet.
- Sticky errors clear only on `reset`.
- Reset during any state: on the next edge the block is in IDLE with reset values, and `tx_write` is 0. An in-flight `uart_tx` byte is left to finish on its own.

## Timing
- Arbitration: `req` sampled in IDLE at edge n → `grant` and `busy` high after edge n+1.
- Issue: `req_ack` pulse and `tx_write` rise after edge n+2, and `tx_byte` is valid on the same edge.
- Requester turnaround: `req_byte`/`req_last` for byte k+1 must be stable from the cycle after the `req_ack` pulse for byte k.
- Byte-to-byte overhead: 2 cycles from the busy falling edge to the next `tx_write`, through WAIT_DONE and LOAD.
- Release to regrant: IDLE is re-entered the cycle after release, so the next owner is granted 2 cycles after the last byte's busy falling edge.
- Simultaneous requests: the pointer order decides; the previous owner has the lowest priority.
- A single requester may win back-to-back packets if no other requester is asserted.

## Test plan
- Single packet: req[1]=1, 3 bytes 0xA5, 0x5A, 0xFF (last on 0xFF), with a `uart_tx` model → `tx_byte` sequence A5, 5A, FF; 3 `req_ack[1]` pulses; `grant` = 0b0010 throughout; `busy` drops after the third busy falling edge.
- Round-robin fairness: req = 0b1111 permanently, each requester sending 1-byte packets → grant order 0, 1, 2, 3, 0, 1; no grant change mid-byte.
- Packet lock: req[0] mid-packet (byte 2 of 4) while req[2] rises → requester 0 completes all 4 bytes before `grant` = 0b0100.
- Abort: req[3] drops after its first byte completes → `abort_err` = 1, `busy` = 0, next grant goes to requester 0 when requested.
- Timeout: `tx_busy` stuck at 0 with TIMEOUT_CYCLES = 16 → `tx_write` high for 16 cycles, then `timeout_err` = 1, `tx_write` = 0, state IDLE.
- Reset mid-packet: assert `reset` during WAIT_DONE of byte 2 → the next cycle has all outputs 0, including the errors; after reset, req = 0b0011 grants requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locked arbiter sharing one uart_tx between
//            NUM_REQ byte-stream requesters, with a per-byte watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_DATA_BITS  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [NUM_REQ*NUM_DATA_BITS-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]               i_req_last,
  output logic [NUM_REQ-1:0]               o_req_ack,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic [$clog2(NUM_REQ)-1:0]       o_grant_id,
  output logic                             o_busy,
  output logic                             o_tx_write,
  output logic [NUM_DATA_BITS-1:0]         o_tx_byte,
  input  logic                             i_tx_busy,
  input  logic                             i_tx_done,
  output logic                             o_abort_err,
  output logic                             o_timeout_err
);

  localparam int                  c_ID_W     = $clog2(NUM_REQ);
  localparam int                  c_WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_WD_W-1:0]   c_WD_MAX   = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_ID_W-1:0]   c_PTR_INIT = c_ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                     r_state;
  logic [c_ID_W-1:0]          r_rr_ptr;
  logic [c_ID_W-1:0]          r_owner;
  logic                       r_last;
  logic                       r_sent;
  logic [c_WD_W-1:0]          r_wd;
  logic                       r_tx_busy_d;
  logic [NUM_REQ-1:0]         r_req_ack;
  logic [NUM_REQ-1:0]         r_grant;
  logic [c_ID_W-1:0]          r_grant_id;
  logic                       r_busy;
  logic                       r_tx_write;
  logic [NUM_DATA_BITS-1:0]   r_tx_byte;
  logic                       r_abort_err;
  logic                       r_timeout_err;

  logic                       w_found;
  logic [c_ID_W-1:0]          w_sel;
  logic                       w_owner_req;
  logic                       w_owner_last;
  logic [NUM_DATA_BITS-1:0]   w_owner_byte;
  logic                       w_busy_fall;

  // Search order is rr_ptr+1, rr_ptr+2, ...; the smallest offset is applied last and wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req[i] && (((int'(r_rr_ptr) + k) % NUM_REQ) == i)) begin
          w_found = 1'b1;
          w_sel   = c_ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_last = 1'b0;
    w_owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (c_ID_W'(i) == r_owner) begin
        w_owner_req  = i_req[i];
        w_owner_last = i_req_last[i];
        w_owner_byte = i_req_byte[i*NUM_DATA_BITS +: NUM_DATA_BITS];
      end
    end
  end

  assign w_busy_fall = i_tx_done && !i_tx_busy && r_tx_busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= c_PTR_INIT;
      r_owner       <= '0;
      r_last        <= 1'b0;
      r_sent        <= 1'b0;
      r_wd          <= '0;
      r_tx_busy_d   <= 1'b0;
      r_req_ack     <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_tx_write    <= 1'b0;
      r_tx_byte     <= '0;
      r_abort_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_busy_d <= i_tx_busy;
      r_req_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_sel;
            r_grant_id <= w_sel;
            r_grant    <= c_ONE << w_sel;
            r_busy     <= 1'b1;
            r_sent     <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!w_owner_req) begin
            // A withdrawal before any byte went out is a clean cancel and costs no turn.
            if (r_sent) begin
              r_abort_err <= 1'b1;
              r_rr_ptr    <= r_owner;
            end
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tx_byte  <= w_owner_byte;
            r_last     <= w_owner_last;
            r_req_ack  <= r_grant;
            r_tx_write <= 1'b1;
            r_wd       <= '0;
            r_sent     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND, S_WAIT_DONE: begin
          if (r_wd == c_WD_MAX) begin
            r_timeout_err <= 1'b1;
            r_tx_write    <= 1'b0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_busy        <= 1'b0;
            r_rr_ptr      <= r_owner;
            r_state       <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (r_state == S_SEND) begin
              if (i_tx_busy) begin
                r_tx_write <= 1'b0;
                r_state    <= S_WAIT_DONE;
              end
            end else if (w_busy_fall) begin
              if (r_last) begin
                r_grant    <= '0;
                r_grant_id <= '0;
                r_busy     <= 1'b0;
                r_rr_ptr   <= r_owner;
                r_state    <= S_IDLE;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ack     = r_req_ack;
  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_busy        = r_busy;
  assign o_tx_write    = r_tx_write;
  assign o_tx_byte     = r_tx_byte;
  assign o_abort_err   = r_abort_err;
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire
